msx_mem_arbiter: RTL

//  Shares one single-port 8-bit system RAM/ROM block between the HPS file-download stream
//  (OSD "BIN" load) and the Z80 bus of the msx1 core. It buffers download bytes in a small FIFO
//  and arbitrates between download writes and CPU reads/writes with a fixed req/ack handshake.
//  It also holds the machine in reset (boot_reset) while an image is loading.

---
 rtl/msx_mem_arbiter_if.sv | 35 +++
 rtl/msx_mem_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/msx_mem_arbiter_if.sv
// Bus bundle between the memory arbiter and its three neighbours: hps_io download,
// Z80 CPU bus and the single-port system RAM.
// cpu_req is a level held with stable we/addr/din until the one-cycle cpu_ack
// (read data valid with it). dl_wr is a one-cycle byte strobe and dl_wait is advisory.
interface msx_mem_arbiter_if #(
  parameter int AW = 16
);
  logic          dl_en;
  logic          dl_wr;
  logic [AW-1:0] dl_addr;
  logic [7:0]    dl_data;
  logic          dl_wait;
  logic          dl_err;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic [7:0]    cpu_dout;
  logic          cpu_ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_we;
  logic [7:0]    mem_q;
  logic          boot_reset;

  modport slave (
    input  dl_en, dl_wr, dl_addr, dl_data, cpu_req, cpu_we, cpu_addr, cpu_din, mem_q,
    output dl_wait, dl_err, cpu_dout, cpu_ack, mem_addr, mem_din, mem_we, boot_reset
  );

  modport master (
    output dl_en, dl_wr, dl_addr, dl_data, cpu_req, cpu_we, cpu_addr, cpu_din, mem_q,
    input  dl_wait, dl_err, cpu_dout, cpu_ack, mem_addr, mem_din, mem_we, boot_reset
  );
endinterface

// File: rtl/msx_mem_arbiter.sv
// Shares the MSX system RAM between buffered HPS download writes and Z80 accesses,
// and holds the core in boot_reset while an image is loading plus a short tail.
module msx_mem_arbiter #(
  parameter int AW           = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_DL_BURST = 8,
  parameter int POST_RST     = 255
) (
  input  logic                clk,
  input  logic                reset,
  msx_mem_arbiter_if.slave    bus,
  output logic [2:0]          dbg_state
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(MAX_DL_BURST + 1);
  localparam logic [PW:0]   CNT_FULL  = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_WAIT  = (PW + 1)'(FIFO_DEPTH - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DL_BURST);
  localparam logic [15:0]   POST_VAL  = 16'(POST_RST);

  typedef enum logic [2:0] {IDLE, DL_WR, CPU_RD, CPU_RDQ, CPU_WR} state_t;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } dl_entry_t;

  state_t        state_q, state_d;
  dl_entry_t     fifo_mem_q [FIFO_DEPTH];
  dl_entry_t     fifo_mem_d [FIFO_DEPTH];
  dl_entry_t     head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [15:0]   post_cnt_q, post_cnt_d;
  logic          dl_wait_q, dl_wait_d, dl_err_q, dl_err_d, dl_en_prev_q, dl_en_prev_d;
  logic          cpu_ack_q, cpu_ack_d, mem_we_q, mem_we_d, boot_reset_q, boot_reset_d;
  logic [7:0]    cpu_dout_q, cpu_dout_d, mem_din_q, mem_din_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          fifo_empty, fifo_full, push, pop, drop, cpu_req_eff, dl_grant;

  always_comb begin
    fifo_empty   = (count_q == '0);
    fifo_full    = (count_q == CNT_FULL);
    head         = fifo_mem_q[rd_ptr_q];
    // The ack cycle still sees the old request level; it must not start a second access.
    cpu_req_eff  = bus.cpu_req & ~cpu_ack_q;
    dl_grant     = !fifo_empty && (!cpu_req_eff || (burst_q < BURST_MAX));
    pop          = (state_q == DL_WR);
    push         = bus.dl_wr & ~fifo_full;
    drop         = bus.dl_wr & fifo_full;

    fifo_mem_d   = fifo_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    state_d      = state_q;
    burst_d      = burst_q;
    cpu_ack_d    = 1'b0;
    cpu_dout_d   = cpu_dout_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;

    if (push) begin
      fifo_mem_d[wr_ptr_q] = {bus.dl_addr, bus.dl_data};
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Outputs are registered: the memory strobes for a state are loaded on entry to it.
    case (state_q)
      IDLE: begin
        if (dl_grant) begin
          state_d    = DL_WR;
          mem_we_d   = 1'b1;
          mem_addr_d = head.addr;
          mem_din_d  = head.data;
        end else if (cpu_req_eff && bus.cpu_we) begin
          state_d    = CPU_WR;
          mem_we_d   = 1'b1;
          mem_addr_d = bus.cpu_addr;
          mem_din_d  = bus.cpu_din;
        end else if (cpu_req_eff) begin
          state_d    = CPU_RD;
          mem_addr_d = bus.cpu_addr;
        end
      end
      DL_WR: begin
        state_d = IDLE;
        if (!cpu_req_eff)             burst_d = '0;
        else if (burst_q != BURST_MAX) burst_d = burst_q + 1'b1;
      end
      CPU_WR: begin
        state_d   = IDLE;
        cpu_ack_d = 1'b1;
        burst_d   = '0;
      end
      CPU_RD: state_d = CPU_RDQ;
      CPU_RDQ: begin
        state_d    = IDLE;
        cpu_dout_d = bus.mem_q;
        cpu_ack_d  = 1'b1;
        burst_d    = '0;
      end
      default: state_d = IDLE;
    endcase

    dl_wait_d    = (count_d >= CNT_WAIT);
    dl_en_prev_d = bus.dl_en;
    dl_err_d     = dl_err_q;
    if (bus.dl_en && !dl_en_prev_q) dl_err_d = 1'b0;
    if (drop)                       dl_err_d = 1'b1;

    // Tail counter: the first idle cycle already counts as one of the POST_RST cycles.
    if (bus.dl_en || !fifo_empty) begin
      post_cnt_d   = POST_VAL;
      boot_reset_d = 1'b1;
    end else if (post_cnt_q > 16'd1) begin
      post_cnt_d   = post_cnt_q - 16'd1;
      boot_reset_d = 1'b1;
    end else begin
      post_cnt_d   = '0;
      boot_reset_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      burst_q      <= '0;
      post_cnt_q   <= POST_VAL;
      dl_wait_q    <= 1'b0;
      dl_err_q     <= 1'b0;
      dl_en_prev_q <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cpu_dout_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      boot_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      burst_q      <= burst_d;
      post_cnt_q   <= post_cnt_d;
      dl_wait_q    <= dl_wait_d;
      dl_err_q     <= dl_err_d;
      dl_en_prev_q <= dl_en_prev_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_dout_q   <= cpu_dout_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      boot_reset_q <= boot_reset_d;
    end
  end

  assign bus.dl_wait    = dl_wait_q;
  assign bus.dl_err     = dl_err_q;
  assign bus.cpu_dout   = cpu_dout_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_din    = mem_din_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.boot_reset = boot_reset_q;
  assign dbg_state      = state_q;
endmodule
